// File: rtl/pmsm_foc_pkg.sv
// pmsm_foc_pkg: shared types and constants for the PMSM FOC current path.
//   DATA_WIDTH : signed width of currents, sin/cos and id/iq. Override it by
//                defining the DATA_WIDTH macro; the default is 16.
//   ACC_WIDTH  : width of intermediate sums (DATA_WIDTH + 2).
//   FRAC_BITS  : fraction bits of sin/cos (1.0 = 2**FRAC_BITS).
//   INV_SQRT3  : round(2**FRAC_BITS / sqrt(3)).
//   park_state_t   : sequencing states of the Clarke/Park engine.
//   sat_to_width() : clamps an ACC_WIDTH value to the DATA_WIDTH signed range.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package pmsm_foc_pkg;

    localparam int DATA_WIDTH = `DATA_WIDTH;
    localparam int ACC_WIDTH  = DATA_WIDTH + 2;
    localparam int FRAC_BITS  = 14;
    localparam int INV_SQRT3  = 9459;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BETA,
        ST_MUL_AC,
        ST_MUL_BS,
        ST_MUL_BC,
        ST_MUL_AS,
        ST_FINAL,
        ST_WRITE
    } park_state_t;

    function automatic logic signed [DATA_WIDTH-1:0] sat_to_width(
        input logic signed [ACC_WIDTH-1:0] x
    );
        logic signed [ACC_WIDTH-1:0] hi;
        logic signed [ACC_WIDTH-1:0] lo;
        hi = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
        lo = ACC_WIDTH'(-(2 ** (DATA_WIDTH - 1)));
        if (x > hi)
            sat_to_width = DATA_WIDTH'(hi);
        else if (x < lo)
            sat_to_width = DATA_WIDTH'(lo);
        else
            sat_to_width = DATA_WIDTH'(x);
    endfunction

endpackage

// File: rtl/fixed_point_mul_shift_module.sv
// fixed_point_mul_shift_module: registered signed multiply followed by an
// arithmetic right shift (truncation toward -inf). One clock of latency.
//   sys_clk    in   1          clock
//   reset_n    in   1          asynchronous reset, active low (clears result)
//   a_in       in   A_WIDTH    signed multiplicand
//   b_in       in   B_WIDTH    signed multiplier
//   result_out out  OUT_WIDTH  (a_in * b_in) >>> SHIFT, low OUT_WIDTH bits
module fixed_point_mul_shift_module #(
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 16,
    parameter int OUT_WIDTH = 18,
    parameter int SHIFT     = 14
) (
    input  logic                        sys_clk,
    input  logic                        reset_n,
    input  logic signed [A_WIDTH-1:0]   a_in,
    input  logic signed [B_WIDTH-1:0]   b_in,
    output logic signed [OUT_WIDTH-1:0] result_out
);

    logic signed [A_WIDTH+B_WIDTH-1:0] product;

    always_comb begin
        product = a_in * b_in;
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n)
            result_out <= '0;
        else
            result_out <= OUT_WIDTH'(product >>> SHIFT);
    end

endmodule

// File: rtl/current_clarke_park_transform_module.sv
// current_clarke_park_transform_module: converts phase currents ia/ib to
// rotor-frame id/iq using one shared registered multiplier.
//   i_beta = (ia + 2*ib) * INV_SQRT3,  id = a*cos + b*sin,  iq = b*cos - a*sin
// Macro PARK_OUTPUT_SAT_EN: when defined, i_beta/id/iq saturate to the
// DATA_WIDTH range; otherwise the low DATA_WIDTH bits are kept (wrap).
// Ports:
//   sys_clk, reset_n (async, active low)
//   electrical_rotation_phase_sin_in/cos_in     signed Q1.FRAC_BITS trig
//   electrical_rotation_phase_trig_calculate_valid_in  strobe: new sin/cos
//   phase_a_current_in/phase_b_current_in       signed ia/ib sample
//   current_sample_valid_in                      strobe: new ia/ib
//   current_d_out/current_q_out                  signed id/iq (held)
//   current_dq_valid_out                         strobe: id/iq updated
//   park_busy_out                                conversion in progress
//   current_sample_overrun_out                   strobe: sample dropped
module current_clarke_park_transform_module
    import pmsm_foc_pkg::*;
(
    input  logic                         sys_clk,
    input  logic                         reset_n,
    input  logic signed [DATA_WIDTH-1:0] electrical_rotation_phase_sin_in,
    input  logic signed [DATA_WIDTH-1:0] electrical_rotation_phase_cos_in,
    input  logic                         electrical_rotation_phase_trig_calculate_valid_in,
    input  logic signed [DATA_WIDTH-1:0] phase_a_current_in,
    input  logic signed [DATA_WIDTH-1:0] phase_b_current_in,
    input  logic                         current_sample_valid_in,
    output logic signed [DATA_WIDTH-1:0] current_d_out,
    output logic signed [DATA_WIDTH-1:0] current_q_out,
    output logic                         current_dq_valid_out,
    output logic                         park_busy_out,
    output logic                         current_sample_overrun_out
);

    function automatic logic signed [DATA_WIDTH-1:0] reduce(
        input logic signed [ACC_WIDTH-1:0] x
    );
`ifdef PARK_OUTPUT_SAT_EN
        reduce = sat_to_width(x);
`else
        reduce = DATA_WIDTH'(x);
`endif
    endfunction

    park_state_t                  state, next_state;
    logic                         trig_valid;
    logic                         trig_locked;
    logic                         accept;
    logic signed [DATA_WIDTH-1:0] sin_hold, cos_hold;
    logic signed [DATA_WIDTH-1:0] sin_c, cos_c, ia_c, beta_r;
    logic signed [ACC_WIDTH-1:0]  sum_r, acc_d, acc_q;
    logic signed [ACC_WIDTH-1:0]  mul_a, mul_out;
    logic signed [DATA_WIDTH-1:0] mul_b;

    assign trig_valid    = electrical_rotation_phase_trig_calculate_valid_in;
    assign accept        = current_sample_valid_in && (state == ST_IDLE) && trig_locked;
    assign park_busy_out = (state != ST_IDLE);

    // Trig holding registers and lock flag
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sin_hold    <= '0;
            cos_hold    <= '0;
            trig_locked <= 1'b0;
        end else if (trig_valid) begin
            sin_hold    <= electrical_rotation_phase_sin_in;
            cos_hold    <= electrical_rotation_phase_cos_in;
            trig_locked <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // ST_WRITE is the output register stage: it keeps the engine busy until
    // id/iq are written so the 8-clock sample cadence holds.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:   if (accept) next_state = ST_BETA;
            ST_BETA:   next_state = ST_MUL_AC;
            ST_MUL_AC: next_state = ST_MUL_BS;
            ST_MUL_BS: next_state = ST_MUL_BC;
            ST_MUL_BC: next_state = ST_MUL_AS;
            ST_MUL_AS: next_state = ST_FINAL;
            ST_FINAL:  next_state = ST_WRITE;
            ST_WRITE:  next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Operands issued in each state; the product lands one state later.
    always_comb begin
        mul_a = ACC_WIDTH'(ia_c);
        mul_b = cos_c;
        unique case (state)
            ST_BETA: begin
                mul_a = sum_r;
                mul_b = DATA_WIDTH'(INV_SQRT3);
            end
            ST_MUL_BS: begin
                mul_a = ACC_WIDTH'(beta_r);
                mul_b = sin_c;
            end
            ST_MUL_BC: begin
                mul_a = ACC_WIDTH'(beta_r);
                mul_b = cos_c;
            end
            ST_MUL_AS: begin
                mul_a = ACC_WIDTH'(ia_c);
                mul_b = sin_c;
            end
            default: begin
                mul_a = ACC_WIDTH'(ia_c);
                mul_b = cos_c;
            end
        endcase
    end

    fixed_point_mul_shift_module #(
        .A_WIDTH   (ACC_WIDTH),
        .B_WIDTH   (DATA_WIDTH),
        .OUT_WIDTH (ACC_WIDTH),
        .SHIFT     (FRAC_BITS)
    ) u_mul (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .a_in       (mul_a),
        .b_in       (mul_b),
        .result_out (mul_out)
    );

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            ia_c                       <= '0;
            sum_r                      <= '0;
            sin_c                      <= '0;
            cos_c                      <= '0;
            beta_r                     <= '0;
            acc_d                      <= '0;
            acc_q                      <= '0;
            current_d_out              <= '0;
            current_q_out              <= '0;
            current_dq_valid_out       <= 1'b0;
            current_sample_overrun_out <= 1'b0;
        end else begin
            current_dq_valid_out       <= 1'b0;
            current_sample_overrun_out <= current_sample_valid_in && (state != ST_IDLE);
            if (accept) begin
                ia_c  <= phase_a_current_in;
                sum_r <= ACC_WIDTH'(phase_a_current_in) + (ACC_WIDTH'(phase_b_current_in) <<< 1);
                // Same-cycle trig strobe bypasses the holding registers
                sin_c <= trig_valid ? electrical_rotation_phase_sin_in : sin_hold;
                cos_c <= trig_valid ? electrical_rotation_phase_cos_in : cos_hold;
            end
            unique case (state)
                ST_MUL_AC: beta_r <= reduce(mul_out);
                ST_MUL_BS: acc_d  <= mul_out;
                ST_MUL_BC: acc_d  <= acc_d + mul_out;
                ST_MUL_AS: acc_q  <= mul_out;
                ST_FINAL:  acc_q  <= acc_q - mul_out;
                ST_WRITE: begin
                    current_d_out        <= reduce(acc_d);
                    current_q_out        <= reduce(acc_q);
                    current_dq_valid_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_current_clarke_park_transform_module.sv
// tb_current_clarke_park_transform_module: directed, table-driven bench for
// the Clarke/Park conversion plus hand-written multi-cycle sequences
// (trig lock, same-cycle bypass, overrun, mid-conversion reset).
// Honours PARK_OUTPUT_SAT_EN for the saturating vector.
module tb_current_clarke_park_transform_module;

    typedef struct {
        string             name;
        logic signed [15:0] sin_v;
        logic signed [15:0] cos_v;
        logic signed [15:0] ia;
        logic signed [15:0] ib;
        logic signed [15:0] exp_id;
        logic signed [15:0] exp_iq;
    } vec_t;

    logic               sys_clk;
    logic               reset_n;
    logic signed [15:0] sin_in, cos_in, ia_in, ib_in;
    logic               trig_v, samp_v;
    logic signed [15:0] id_out, iq_out;
    logic               dq_valid, busy, overrun;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[8];

    current_clarke_park_transform_module dut (
        .sys_clk                                           (sys_clk),
        .reset_n                                           (reset_n),
        .electrical_rotation_phase_sin_in                  (sin_in),
        .electrical_rotation_phase_cos_in                  (cos_in),
        .electrical_rotation_phase_trig_calculate_valid_in (trig_v),
        .phase_a_current_in                                (ia_in),
        .phase_b_current_in                                (ib_in),
        .current_sample_valid_in                           (samp_v),
        .current_d_out                                     (id_out),
        .current_q_out                                     (iq_out),
        .current_dq_valid_out                              (dq_valid),
        .park_busy_out                                     (busy),
        .current_sample_overrun_out                        (overrun)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input int s, input int c, input int a,
                                input int b, input int eid, input int eiq);
        vec_t v;
        v.name = n; v.sin_v = 16'(s); v.cos_v = 16'(c); v.ia = 16'(a); v.ib = 16'(b);
        v.exp_id = 16'(eid); v.exp_iq = 16'(eiq);
        return v;
    endfunction

    task automatic send_trig(input logic signed [15:0] s, input logic signed [15:0] c);
        sin_in = s; cos_in = c; trig_v = 1'b1;
        tick();
        trig_v = 1'b0;
    endtask

    // Drives one accepted sample; returns at E0 + 1.
    task automatic start_sample(input string name, input logic signed [15:0] a,
                                input logic signed [15:0] b);
        ia_in = a; ib_in = b; samp_v = 1'b1;
        tick();
        samp_v = 1'b0;
        check({name, "_busy"}, int'(busy), 1);
    endtask

    // Called at E0 + 1; expects the result strobe at E7 + 1.
    task automatic await_result(input string name, input logic signed [15:0] eid,
                                input logic signed [15:0] eiq);
        int lat = 0;
        while (!dq_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({name, "_latency"}, lat, 7);
        check({name, "_id"}, int'(id_out), int'(eid));
        check({name, "_iq"}, int'(iq_out), int'(eiq));
        check({name, "_idle_at_valid"}, int'(busy), 0);
        tick();
        check({name, "_valid_1cyc"}, int'(dq_valid), 0);
    endtask

    // Counts strobes over n cycles; used where nothing may happen.
    task automatic watch_quiet(input string name, input int n);
        int seen_v = 0, seen_o = 0, seen_b = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (dq_valid) seen_v++;
            if (overrun) seen_o++;
            if (busy) seen_b++;
        end
        check({name, "_no_valid"}, seen_v, 0);
        check({name, "_no_overrun"}, seen_o, 0);
        check({name, "_no_busy"}, seen_b, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        sin_in = '0; cos_in = '0; ia_in = '0; ib_in = '0;
        trig_v = 1'b0; samp_v = 1'b0;

        vecs[0] = mk("cos1_ia",   0,      16384,  1000,  0,     1000,  577);
        vecs[1] = mk("sin1_ia",   16384,  0,      1000,  0,     577,   -1000);
        vecs[2] = mk("neg_ia",    0,      16384,  -1000, 0,     -1000, -578);
        vecs[3] = mk("ib_only",   0,      16384,  0,     1000,  0,     1154);
        vecs[4] = mk("cos_neg",   0,      -16384, 1000,  0,     -1000, -577);
        vecs[5] = mk("sin1_ib",   16384,  0,      0,     1000,  1154,  0);
        vecs[6] = mk("deg45_mid", 11585,  11585,  1000,  0,     1114,  -300);
`ifdef PARK_OUTPUT_SAT_EN
        vecs[7] = mk("deg45_full", 11585, 11585,  32767, 32767, 32767, 0);
`else
        vecs[7] = mk("deg45_full", 11585, 11585,  32767, 32767, 16957, -29381);
`endif

        // Reset state
        repeat (3) tick();
        check("rst_id", int'(id_out), 0);
        check("rst_iq", int'(iq_out), 0);
        check("rst_valid", int'(dq_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        reset_n = 1'b1;
        tick();

        // Samples before any trig strobe are ignored silently
        ia_in = 16'sd1000; ib_in = '0; samp_v = 1'b1;
        tick();
        samp_v = 1'b0;
        check("unlocked_busy", int'(busy), 0);
        watch_quiet("unlocked", 12);

        // Table-driven conversions
        for (int i = 0; i < 8; i++) begin
            send_trig(vecs[i].sin_v, vecs[i].cos_v);
            start_sample(vecs[i].name, vecs[i].ia, vecs[i].ib);
            await_result(vecs[i].name, vecs[i].exp_id, vecs[i].exp_iq);
        end

        // Same-cycle trig strobe is used for the accepted sample
        send_trig(16'sd0, 16'sd16384);
        tick();
        sin_in = 16'sd16384; cos_in = 16'sd0; trig_v = 1'b1;
        start_sample("bypass", 16'sd1000, 16'sd0);
        trig_v = 1'b0;
        await_result("bypass", 16'sd577, -16'sd1000);

        // Overrun: strobe at E3 dropped, strobe at E8 accepted
        send_trig(16'sd0, 16'sd16384);
        start_sample("ovr_first", 16'sd1000, 16'sd0);   // E0
        tick(); tick();                                 // E2
        ia_in = 16'sd5000; samp_v = 1'b1;
        tick();                                         // E3
        samp_v = 1'b0;
        check("ovr_pulse", int'(overrun), 1);
        tick();                                         // E4
        check("ovr_pulse_end", int'(overrun), 0);
        tick(); tick(); tick();                         // E7
        check("ovr_first_valid", int'(dq_valid), 1);
        check("ovr_first_id", int'(id_out), 1000);
        check("ovr_first_iq", int'(iq_out), 577);
        start_sample("ovr_e8", -16'sd1000, 16'sd0);     // E8
        check("ovr_e8_no_overrun", int'(overrun), 0);
        await_result("ovr_e8", -16'sd1000, -16'sd578);

        // Reset during MUL_BS aborts the conversion and drops the trig lock
        send_trig(16'sd0, 16'sd16384);
        start_sample("abort", 16'sd2000, 16'sd0);        // E0: BETA
        tick(); tick();                                 // MUL_BS
        reset_n = 1'b0;
        #1;
        check("abort_id", int'(id_out), 0);
        check("abort_iq", int'(iq_out), 0);
        check("abort_valid", int'(dq_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_overrun", int'(overrun), 0);
        tick();
        reset_n = 1'b1;
        watch_quiet("post_abort", 10);
        ia_in = 16'sd1000; ib_in = '0; samp_v = 1'b1;
        tick();
        samp_v = 1'b0;
        watch_quiet("relock_needed", 10);
        send_trig(16'sd0, 16'sd16384);
        start_sample("relocked", 16'sd1000, 16'sd0);
        await_result("relocked", 16'sd1000, 16'sd577);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
